aespim_issue_ctrl: RTL and testbench
====================================

# aespim_issue_ctrl

Issue controller that sits directly upstream of the AES-PIM accelerator datapath. It accepts AES custom-instruction requests from the core over a valid/ready handshake and buffers them in a small FIFO. It issues one request per cycle to the accelerator as a `start` pulse with op code and operand, then captures the accelerator's same-cycle result and returns it to the core over a valid/ready response channel. It also tracks the column slot position of the 4-word accelerator state.

## Interface
Parameters:
- `DEPTH`, default 4: request FIFO entries; power of two, ≥2.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  1  core request valid.
- `req_ready_o`  out  1  FIFO can accept a request.
- `req_op_i`  in  5  `[2:0]` op code (package `OP_*`), `[4:3]` shift-row code.
- `req_data_i`  in  32  operand word.
- `rsp_valid_o`  out  1  result available.
- `rsp_ready_i`  in  1  core consumes the result.
- `rsp_data_o`  out  32  result word.
- `flush_i`  in  1  discard all queued, not-yet-issued requests.
- `acc_start_o`  out  1  one-cycle issue strobe to the accelerator.
- `acc_op_o`  out  5  op code to the accelerator; pass-through of `req_op_i`.
- `acc_data_o`  out  32  operand to the accelerator.
- `acc_data_i`  in  32  accelerator result. Combinational, valid in the issue cycle.
- `col_o`  out  2  current state column slot, equal to the number of issued ops mod 4.
- `busy_o`  out  1  FIFO non-empty or response pending.

## Operation
- Enqueue: when `req_valid_i && req_ready_o && !flush_i`, push `{op, data}`. `req_ready_o = !full`.
- Issue condition: FIFO not empty, no flush this cycle, and the response slot is free. The slot is free when `!rsp_valid_o || rsp_ready_i`.
- On issue:
  - `acc_start_o=1`; `acc_op_o`/`acc_data_o` = FIFO head.
  - Pop the head.
  - Register `acc_data_i` into `rsp_data_o`; set `rsp_valid_o` next cycle.
  - Increment `col_q` mod 4.
- When not issuing: `acc_start_o=0`, `acc_op_o` = head op (0 if empty), `acc_data_o=0`.
- Every request produces exactly one response. For `OP_LD`, `OP_ENCI`, `OP_DECM` and `OP_ENCF`, `rsp_data_o` is whatever the accelerator drives, which is 0.
- Response is held stable while `rsp_valid_o && !rsp_ready_i`. It clears when it is accepted and no new issue occurs in the same cycle.
- FSM `ctrl_q`:
  - IDLE: FIFO empty, no response pending.
  - RUN: FIFO non-empty and slot free → issue each cycle.
  - HOLD: response pending and `!rsp_ready_i` → no issue.
  - Transitions are evaluated from FIFO count and response state each cycle. A flush in any state → IDLE if no response is pending, else HOLD.
- Flush: pointers and count go to 0. A same-cycle push is dropped. The pending response, `col_q`, and the accelerator state are untouched.
- Simultaneous push and pop when full: the pop frees a slot, but `req_ready_o` is based on registered full, so no push happens that cycle.
- Simultaneous push and pop otherwise: count unchanged.
- Pointer wrap-around: modulo DEPTH.
- Reset values: FIFO empty, `req_ready_o=1`, `rsp_valid_o=0`, `rsp_data_o=0`, `acc_start_o=0`, `acc_op_o=0`, `acc_data_o=0`, `col_o=0`, `busy_o=0`, FSM IDLE.
- Reset mid-operation drops all queued requests and any pending response.

## Timing
- Request accepted in cycle N → earliest issue is cycle N+1 (no fall-through). `rsp_valid_o` rises in cycle N+2.
- Throughput is 1 op/cycle while `rsp_ready_i` is held high.
- `rsp_ready_i` low in cycle M → no issue in M. Issue resumes in the cycle `rsp_ready_i` is high.
- `acc_start_o` is never high for two ops with the same FIFO entry.
- `acc_start_o` is never high in a flush cycle.
- `col_o` updates the cycle after the issue.

## Structure
- `aespim_pkg` holds:
  - the `OP_*` op-code constants;
  - a `aespim_req_t` struct `{logic [4:0] op; logic [31:0] data;}`;
  - an `aespim_ctrl_e` enum for IDLE/RUN/HOLD.
- One sub-module, `aespim_req_fifo`: a parameterised synchronous FIFO of `aespim_req_t` with push, pop, flush, full, empty, and head outputs.
- The top level holds the FSM, response register, and column counter. It connects to the accelerator's `start_i`/`op_code_i`/`data_in_i`/`data_out_o` ports.

## Test plan
- **Single LD:** push `OP_LD`, data `32'h00112233` at cycle 0, `rsp_ready_i=1` → `acc_start_o` at cycle 1 with data `00112233`; `rsp_valid_o` at cycle 2 with `rsp_data_o=0`; `col_o=1`.
- **Back-to-back:** four `OP_LD` then one `OP_ST` on consecutive cycles → five consecutive `acc_start_o` cycles. The ST response equals `acc_data_i` from the ST issue cycle. `col_o` sequence: 1, 2, 3, 0, 1.
- **Backpressure:** `rsp_ready_i=0` after the first response with 3 requests queued → no `acc_start_o`, and `rsp_data_o` is stable. Raise `rsp_ready_i` → the next issue occurs in that same cycle.
- **Full:** with DEPTH=4 and `rsp_ready_i=0`, push 6 requests → `req_ready_o` drops after 5 accepted (1 issued plus 4 queued). No request is lost once ready is restored.
- **Flush:** 3 requests queued, pulse `flush_i` with a simultaneous push → no issue that cycle, FIFO empty after, the pushed request is dropped, and the pending response still completes.
- **Reset mid-stream:** assert `rst_ni=0` asynchronously with 2 requests queued and a response pending → all outputs take their reset values immediately. After release, a new LD issues normally with `col_o` counting from 0.

Source files
------------

// File: rtl/aespim_pkg.sv
// Shared types for the AES-PIM issue path: op codes, the queued request
// record and the issue controller state encoding.
package aespim_pkg;

  localparam logic [2:0] OP_LD   = 3'd0;
  localparam logic [2:0] OP_ST   = 3'd1;
  localparam logic [2:0] OP_ENCI = 3'd2;
  localparam logic [2:0] OP_ENCM = 3'd3;
  localparam logic [2:0] OP_ENCF = 3'd4;
  localparam logic [2:0] OP_DECI = 3'd5;
  localparam logic [2:0] OP_DECM = 3'd6;
  localparam logic [2:0] OP_DECF = 3'd7;

  localparam int OP_W   = 5;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] data;
  } aespim_req_t;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'd0,
    CTRL_RUN  = 2'd1,
    CTRL_HOLD = 2'd2
  } aespim_ctrl_e;

endpackage

// File: rtl/aespim_req_fifo.sv
// Request FIFO in front of the accelerator. Head is read combinationally;
// flush drops every queued entry and any same-cycle push or pop.
module aespim_req_fifo
  import aespim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  aespim_req_t              req_in,
  output aespim_req_t              head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  aespim_req_t       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;
  logic              do_push, do_pop;

  assign full    = (cnt == CW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];
  assign count   = cnt;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= req_in;
  end

endmodule

// File: rtl/aespim_issue_ctrl.sv
// Issue controller for the AES-PIM datapath: queues core requests, issues one
// per cycle as a start strobe, and returns the same-cycle accelerator result.
module aespim_issue_ctrl
  import aespim_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [4:0]        req_op_i,
  input  logic [31:0]       req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  input  logic              flush_i,
  output logic              acc_start_o,
  output logic [4:0]        acc_op_o,
  output logic [31:0]       acc_data_o,
  input  logic [31:0]       acc_data_i,
  output logic [1:0]        col_o,
  output logic              busy_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  aespim_req_t   req_in, head;
  logic          push, full, empty, issue, slot_free, rsp_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic [1:0]    col_q;
  aespim_ctrl_e  ctrl_q, ctrl_d;

  assign req_in    = '{op: req_op_i, data: req_data_i};
  assign req_ready_o = !full;
  assign push      = req_valid_i && !full && !flush_i;
  assign slot_free = !rsp_valid_q || rsp_ready_i;
  assign issue     = !empty && !flush_i && slot_free;

  aespim_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .pop    (issue),
    .flush  (flush_i),
    .req_in (req_in),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (cnt)
  );

  assign acc_start_o = issue;
  assign acc_op_o    = empty ? '0 : head.op;
  assign acc_data_o  = issue ? head.data : '0;

  // The result register reloads in the same cycle the previous one is taken,
  // which is what gives back-to-back throughput.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (issue) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= acc_data_i;
    end else if (rsp_ready_i) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    col_q <= '0;
    else if (issue) col_q <= col_q + 2'd1;
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign col_o       = col_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ctrl_q <= CTRL_IDLE;
    else         ctrl_q <= ctrl_d;
  end

  // HOLD covers both a stalled response and a lone response draining; IDLE is
  // entered only when nothing is queued and nothing is owed to the core.
  always_comb begin
    ctrl_d  = ctrl_q;
    rsp_nxt = issue || (rsp_valid_q && !rsp_ready_i);
    cnt_nxt = flush_i ? '0 : cnt + CW'(push) - CW'(issue);
    if (flush_i)                          ctrl_d = rsp_nxt ? CTRL_HOLD : CTRL_IDLE;
    else if (rsp_valid_q && !rsp_ready_i) ctrl_d = CTRL_HOLD;
    else if (cnt_nxt != '0)               ctrl_d = CTRL_RUN;
    else if (rsp_nxt)                     ctrl_d = CTRL_HOLD;
    else                                  ctrl_d = CTRL_IDLE;
  end

  assign busy_o = (ctrl_q != CTRL_IDLE);

endmodule

// File: tb/tb_aespim_issue_ctrl.sv
// Directed bench for aespim_issue_ctrl with a scoreboard monitor that matches
// issues and responses against the requests the stimulus handed over.
module tb_aespim_issue_ctrl;
  import aespim_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [4:0]  req_op_i = '0;
  logic [31:0] req_data_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_data_o;
  logic        flush_i = 1'b0;
  logic        acc_start_o;
  logic [4:0]  acc_op_o;
  logic [31:0] acc_data_o;
  logic [31:0] acc_data_i;
  logic [1:0]  col_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] data;
    logic [31:0] exp;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] rq[$];
  logic [31:0] req_exp = '0;
  logic        hold_seen = 1'b0;
  logic [31:0] hold_data = '0;

  aespim_issue_ctrl #(.DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .flush_i     (flush_i),
    .acc_start_o (acc_start_o),
    .acc_op_o    (acc_op_o),
    .acc_data_o  (acc_data_o),
    .acc_data_i  (acc_data_i),
    .col_o       (col_o),
    .busy_o      (busy_o)
  );

  // Accelerator stand-in: ST returns the operand with halves swapped, all else 0.
  assign acc_data_i = (acc_start_o && acc_op_o[2:0] == OP_ST) ?
                      {acc_data_o[15:0], acc_data_o[31:16]} : 32'h0;

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(input logic v, input logic [4:0] op, input logic [31:0] d,
                         input logic [31:0] e);
    req_valid_i = v;
    req_op_i    = op;
    req_data_i  = d;
    req_exp     = e;
  endtask

  task automatic do_reset();
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    flush_i = 1'b0;
    rst_ni  = 1'b0;
    step();
    step();
    rst_ni  = 1'b1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", req_ready_o, 1);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_data",  rsp_data_o,  0);
    chk("rst_acc_start", acc_start_o, 0);
    chk("rst_acc_op",    acc_op_o,    0);
    chk("rst_acc_data",  acc_data_o,  0);
    chk("rst_col",       col_o,       0);
    chk("rst_busy",      busy_o,      0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    rsp_ready_i = 1'b1;
    while (busy_o && n < 50) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n >= 50), 0);
    step();
  endtask

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    ent_t e;
    if (!rst_ni) begin
      mq.delete();
      rq.delete();
      hold_seen = 1'b0;
    end else begin
      if (hold_seen) begin
        chk("rsp_hold_valid", rsp_valid_o, 1);
        chk("rsp_hold_data",  rsp_data_o,  hold_data);
      end
      if (rsp_valid_o && rsp_ready_i) begin
        total++;
        if (rq.size() == 0) begin
          bad++;
          $display("FAIL rsp_unexpected: got response %h want none", rsp_data_o);
        end else if (rsp_data_o !== rq[0]) begin
          bad++;
          $display("FAIL rsp_data: got %h want %h", rsp_data_o, rq[0]);
          void'(rq.pop_front());
        end else begin
          void'(rq.pop_front());
        end
      end
      if (flush_i) chk("start_in_flush", acc_start_o, 0);
      if (acc_start_o) begin
        total++;
        if (mq.size() == 0) begin
          bad++;
          $display("FAIL issue_unexpected: got start op=%h data=%h want no issue",
                   acc_op_o, acc_data_o);
        end else begin
          total--;
          e = mq.pop_front();
          chk("issue_op",   acc_op_o,   e.op);
          chk("issue_data", acc_data_o, e.data);
          rq.push_back(e.exp);
        end
      end else begin
        chk("idle_acc_data", acc_data_o, 0);
      end
      if (req_valid_i && req_ready_o && !flush_i)
        mq.push_back('{req_op_i, req_data_i, req_exp});
      if (flush_i) mq.delete();
      hold_seen = rsp_valid_o && !rsp_ready_i;
      hold_data = rsp_data_o;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, accepted, drop_at;
    logic [4:0]  fop [6];
    logic [31:0] fdat[6];
    logic [31:0] fexp[6];

    // Reset values
    #1 rst_ni = 1'b0;
    #3 chk_reset_vals();
    step();
    step();
    rst_ni = 1'b1;

    // Single LD: issue at cycle 1, response at cycle 2
    rsp_ready_i = 1'b1;
    set_req(1'b1, {2'b00, OP_LD}, 32'h00112233, 32'h0);
    step();
    chk("ld_start", acc_start_o, 1);
    chk("ld_issue_data", acc_data_o, 32'h00112233);
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    step();
    chk("ld_rsp_valid", rsp_valid_o, 1);
    chk("ld_rsp_data", rsp_data_o, 32'h0);
    chk("ld_col", col_o, 1);
    step();

    // Back-to-back: 4 LD + 1 ST
    do_reset();
    rsp_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4)       set_req(1'b1, {2'b01, OP_LD}, 32'h1000_0000 + 32'(k), 32'h0);
      else if (k == 4) set_req(1'b1, {2'b10, OP_ST}, 32'hDEADBEEF, 32'hBEEFDEAD);
      else             set_req(1'b0, 5'd0, 32'h0, 32'h0);
      step();
      chk("b2b_start", acc_start_o, 32'(k < 5));
      if (k >= 1) chk("b2b_col", col_o, 32'(k % 4));
    end
    chk("b2b_st_rsp", rsp_data_o, 32'hBEEFDEAD);
    drain();

    // Backpressure
    do_reset();
    rsp_ready_i = 1'b1;
    set_req(1'b1, {2'b00, OP_ST}, 32'h11112222, 32'h22221111);
    step();
    set_req(1'b1, {2'b00, OP_ST}, 32'h33334444, 32'h44443333);
    step();
    rsp_ready_i = 1'b0;
    set_req(1'b1, {2'b00, OP_ST}, 32'h55556666, 32'h66665555);
    #1 chk("bp_no_start_c2", acc_start_o, 0);
    step();
    set_req(1'b1, {2'b00, OP_ST}, 32'h77778888, 32'h88887777);
    chk("bp_no_start_c3", acc_start_o, 0);
    chk("bp_rsp_data_c3", rsp_data_o, 32'h22221111);
    step();
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    chk("bp_no_start_c4", acc_start_o, 0);
    chk("bp_busy", busy_o, 1);
    step();
    chk("bp_no_start_c5", acc_start_o, 0);
    chk("bp_rsp_data_c5", rsp_data_o, 32'h22221111);
    rsp_ready_i = 1'b1;
    #1 chk("bp_resume_start", acc_start_o, 1);
    chk("bp_resume_data", acc_data_o, 32'h33334444);
    drain();

    // Full: rsp_ready low, 6 requests, ready must drop after 5 accepted
    do_reset();
    rsp_ready_i = 1'b0;
    fop[0] = {2'b00, OP_LD};   fdat[0] = 32'h000000A0; fexp[0] = 32'h0;
    fop[1] = {2'b01, OP_ST};   fdat[1] = 32'h0000FFFF; fexp[1] = 32'hFFFF0000;
    fop[2] = {2'b10, OP_ENCI}; fdat[2] = 32'h000000A2; fexp[2] = 32'h0;
    fop[3] = {2'b11, OP_ST};   fdat[3] = 32'h12345678; fexp[3] = 32'h56781234;
    fop[4] = {2'b00, OP_DECM}; fdat[4] = 32'h000000A4; fexp[4] = 32'h0;
    fop[5] = {2'b01, OP_ST};   fdat[5] = 32'hCAFEF00D; fexp[5] = 32'hF00DCAFE;
    accepted = 0;
    drop_at  = -1;
    for (int i = 0; i < 6; i++) begin
      set_req(1'b1, fop[i], fdat[i], fexp[i]);
      n = 0;
      while (!req_ready_o && n < 30) begin
        if (n == 0 && drop_at < 0) drop_at = accepted;
        if (n < 3) chk("full_no_start", acc_start_o, 0);
        if (n == 3) rsp_ready_i = 1'b1;
        n++;
        step();
      end
      chk("full_accept_timeout", 32'(n >= 30), 0);
      step();
      accepted++;
    end
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    chk("full_drop_at", drop_at, 5);
    drain();

    // Flush with simultaneous push; pending response still completes
    do_reset();
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_req(1'b1, {2'b00, OP_LD}, 32'h0000_00F0 + 32'(k), 32'h0);
      step();
    end
    flush_i     = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(1'b1, {2'b00, OP_ST}, 32'hBAD0BAD0, 32'hBAD0BAD0);
    #1 chk("flush_no_start", acc_start_o, 0);
    chk("flush_rsp_pending", rsp_valid_o, 1);
    step();
    flush_i = 1'b0;
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    chk("flush_busy", busy_o, 0);
    chk("flush_rsp_valid", rsp_valid_o, 0);
    chk("flush_req_ready", req_ready_o, 1);
    chk("flush_acc_op", acc_op_o, 0);
    step();
    chk("flush_no_late_start", acc_start_o, 0);
    chk("flush_col", col_o, 1);

    // Reset mid-stream
    rsp_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_req(1'b1, {2'b00, OP_LD}, 32'h0000_0E00 + 32'(k), 32'h0);
      step();
    end
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    chk("mid_busy_before", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1 chk_reset_vals();
    step();
    step();
    rst_ni      = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(1'b1, {2'b00, OP_LD}, 32'h00000077, 32'h0);
    step();
    set_req(1'b0, 5'd0, 32'h0, 32'h0);
    chk("post_rst_start", acc_start_o, 1);
    chk("post_rst_col0", col_o, 0);
    step();
    chk("post_rst_col1", col_o, 1);
    chk("post_rst_rsp_valid", rsp_valid_o, 1);
    drain();

    chk("sb_rsp_left", rq.size(), 0);
    chk("sb_req_left", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
